// File: rtl/systolic_matmul_os.sv
// NxN output-stationary systolic integer matrix multiplier with valid/ready load and return.
// Define MATMUL_SAT_EN to clamp results to OUT_W instead of wrapping.
module systolic_matmul_os #(
    parameter int W     = 16,
    parameter int N     = 3,
    parameter int OUT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [W*N*N-1:0]     i_A,
    input  logic [W*N*N-1:0]     i_B,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_W*N*N-1:0] o_C,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int ACC_W = 2*W + $clog2(N) + 1;
    localparam int P_W   = 2*W + 2;
    localparam int CNT_W = $clog2(3*N);
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic [W*N*N-1:0] a_q, b_q;

    logic signed [W:0]       a_pipe [N][N];
    logic signed [W:0]       b_pipe [N][N];
    logic signed [ACC_W-1:0] acc    [N][N];
    logic signed [W:0]       a_feed [N];
    logic signed [W:0]       b_feed [N];
    logic [OUT_W*N*N-1:0]    c_red;

    logic accept;

    assign o_ready = (state == IDLE) && !i_rst;
    assign o_busy  = (state == RUN);
    assign accept  = i_en && i_valid && (state == IDLE);

    // Edge feeds: row r sees A[r][t-r], column c sees B[t-c][c], zero outside.
    always_comb begin
        int k;
        logic [W-1:0] e;
        for (int i = 0; i < N; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            k = int'(cnt) - i;
            if (k >= 0 && k < N) begin
                e = a_q[(i*N+k)*W +: W];
                a_feed[i] = {mode_q & e[W-1], e};
                e = b_q[(k*N+i)*W +: W];
                b_feed[i] = {mode_q & e[W-1], e};
            end else begin
                e = '0;
            end
        end
    end

`ifdef MATMUL_SAT_EN
    function automatic logic [OUT_W-1:0] sat_elem(
        input logic signed [ACC_W-1:0] v,
        input logic                    sgn
    );
        logic signed [EXT_W-1:0] e;
        e = EXT_W'(v);
        sat_elem = e[OUT_W-1:0];
        if (sgn) begin
            if (e[EXT_W-1:OUT_W-1] != {(EXT_W-OUT_W+1){e[EXT_W-1]}})
                sat_elem = e[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end else if (|e[EXT_W-1:OUT_W]) begin
            sat_elem = '1;
        end
    endfunction
`endif

    always_comb begin
        c_red = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
`ifdef MATMUL_SAT_EN
                c_red[(r*N+c)*OUT_W +: OUT_W] = sat_elem(acc[r][c], mode_q);
`else
                c_red[(r*N+c)*OUT_W +: OUT_W] = OUT_W'(acc[r][c]);
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            o_C     <= '0;
        end else if (i_en) begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    a_q    <= i_A;
                    b_q    <= i_B;
                    mode_q <= i_mode;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(3*N-1)) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_done  <= 1'b1;
                        o_C     <= c_red;
                    end
                end
                DONE: if (i_ready) begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands travel right along rows and down columns; PEs accumulate in place.
    always_ff @(posedge i_clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (i_rst || accept) begin
                    a_pipe[r][c] <= '0;
                    b_pipe[r][c] <= '0;
                    acc[r][c]    <= '0;
                end else if (i_en && state == RUN) begin
                    a_pipe[r][c] <= (c == 0) ? a_feed[r] : a_pipe[r][(c == 0) ? 0 : c-1];
                    b_pipe[r][c] <= (r == 0) ? b_feed[c] : b_pipe[(r == 0) ? 0 : r-1][c];
                    acc[r][c]    <= acc[r][c]
                                  + ACC_W'(P_W'(a_pipe[r][c]) * P_W'(b_pipe[r][c]));
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_matmul_os.sv
// Directed testbench for systolic_matmul_os (W=16, N=3, OUT_W=32).
// Overflow expectation follows MATMUL_SAT_EN.
module tb_systolic_matmul_os;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_en = 1'b1;
    logic         i_mode = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [143:0] i_A = '0;
    logic [143:0] i_B = '0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [287:0] o_C;
    logic         o_busy;
    logic         o_done;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    systolic_matmul_os #(.W(16), .N(3), .OUT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode),
        .i_valid(i_valid), .o_ready(o_ready), .i_A(i_A), .i_B(i_B),
        .o_valid(o_valid), .i_ready(i_ready), .o_C(o_C),
        .o_busy(o_busy), .o_done(o_done)
    );

    task automatic start_job(input logic [143:0] a, input logic [143:0] b, input logic md);
        i_A = a; i_B = b; i_mode = md; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(input int s_at, input int s_len, output int lat, output int dones);
        lat = 0; dones = 0;
        while (!o_valid && lat < 60) begin
            i_en = !(lat >= s_at && lat < s_at + s_len);
            @(posedge i_clk); #1;
            lat++;
            if (o_done) dones++;
        end
        i_en = 1'b1;
    endtask

    task automatic finish_job();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({o_ready, o_valid, o_busy, o_done} !== 4'b0000 || o_C !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b done=%b C=%h required all 0",
                     o_ready, o_valid, o_busy, o_done, o_C);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b required 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_ones();
        int lat, dones;
        start_job({9{16'h0001}}, {9{16'h0001}}, 1'b0);
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL ones_accept: busy=%b rdy=%b required 1 0", o_busy, o_ready);
        end
        wait_valid(99, 0, lat, dones);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL ones_latency: got %0d required 9", lat);
        end
        checks++;
        if (o_C !== {9{32'd3}}) begin
            errors++;
            $display("FAIL ones_result: got %h required all 3", o_C);
        end
        @(posedge i_clk); #1;
        if (o_done) dones++;
        checks++;
        if (dones !== 1 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL ones_done_pulse: pulses=%0d vld=%b required 1 1", dones, o_valid);
        end
        finish_job();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ones_transfer: vld=%b rdy=%b required 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_identity();
        int lat, dones;
        logic [143:0] a, b;
        logic [287:0] exp_c;
        a = '0; b = '0; exp_c = '0;
        for (int i = 0; i < 9; i++) begin
            b[i*16 +: 16] = 16'(i + 1);
            exp_c[i*32 +: 32] = 32'(i + 1);
        end
        for (int i = 0; i < 3; i++) a[(i*3+i)*16 +: 16] = 16'd1;
        start_job(a, b, 1'b1);
        wait_valid(99, 0, lat, dones);
        checks++;
        if (o_C !== exp_c || lat !== 9) begin
            errors++;
            $display("FAIL identity: got %h lat %0d required %h lat 9", o_C, lat, exp_c);
        end
        finish_job();
    endtask

    task automatic test_signed();
        int lat, dones;
        start_job({9{16'hFFFF}}, {9{16'h0002}}, 1'b1);
        wait_valid(99, 0, lat, dones);
        checks++;
        if (o_C !== {9{32'hFFFFFFFA}}) begin
            errors++;
            $display("FAIL signed_mode1: got %h required all FFFFFFFA", o_C);
        end
        finish_job();
        start_job({9{16'hFFFF}}, {9{16'h0002}}, 1'b0);
        wait_valid(99, 0, lat, dones);
        checks++;
        if (o_C !== {9{32'd393210}}) begin
            errors++;
            $display("FAIL signed_mode0: got %h required all 393210", o_C);
        end
        finish_job();
    endtask

    task automatic test_overflow();
        int lat, dones;
        logic [31:0] exp_e;
`ifdef MATMUL_SAT_EN
        exp_e = 32'hFFFFFFFF;
`else
        exp_e = 32'hFFFA0003;
`endif
        start_job({9{16'hFFFF}}, {9{16'hFFFF}}, 1'b0);
        wait_valid(99, 0, lat, dones);
        checks++;
        if (o_C !== {9{exp_e}}) begin
            errors++;
            $display("FAIL overflow: got %h required all %h", o_C, exp_e);
        end
        finish_job();
    endtask

    task automatic test_backpressure();
        int lat, dones;
        start_job({9{16'h0001}}, {9{16'h0002}}, 1'b0);
        wait_valid(99, 0, lat, dones);
        i_valid = 1'b1;
        i_A = {9{16'h0005}};
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_C !== {9{32'd6}}) begin
                errors++;
                $display("FAIL backpressure_hold%0d: vld=%b rdy=%b C=%h required 1 0 all 6",
                         i, o_valid, o_ready, o_C);
            end
        end
        i_valid = 1'b0;
        finish_job();
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: rdy=%b busy=%b required 1 0", o_ready, o_busy);
        end
    endtask

    task automatic test_stall();
        int lat, dones;
        start_job({9{16'h0001}}, {9{16'h0001}}, 1'b0);
        wait_valid(3, 4, lat, dones);
        checks++;
        if (lat !== 13 || o_C !== {9{32'd3}}) begin
            errors++;
            $display("FAIL stall: lat %0d C=%h required lat 13 all 3", lat, o_C);
        end
        finish_job();
    endtask

    task automatic test_reset_mid_run();
        int lat, dones;
        logic seen;
        start_job({9{16'h0007}}, {9{16'h0007}}, 1'b0);
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_ready, o_valid, o_busy, o_done} !== 4'b0000 || o_C !== '0) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b vld=%b busy=%b C=%h required all 0",
                     o_ready, o_valid, o_busy, o_C);
        end
        i_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_discard: valid_seen=%b rdy=%b required 0 1", seen, o_ready);
        end
        start_job({9{16'h0001}}, {9{16'h0001}}, 1'b0);
        wait_valid(99, 0, lat, dones);
        checks++;
        if (lat !== 9 || o_C !== {9{32'd3}}) begin
            errors++;
            $display("FAIL midrun_next_job: lat %0d C=%h required lat 9 all 3", lat, o_C);
        end
        finish_job();
    endtask

    initial begin
        test_reset();
        test_ones();
        test_identity();
        test_signed();
        test_overflow();
        test_backpressure();
        test_stall();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
